sync_updown_ctr_p: RTL and testbench

Parametrised synchronous up/down counter: the generalised successor of the fixed 5-bit, 0..20 counter. It adds configurable width and bounds, a per-cycle choice of wrap or saturate, a parallel load, and registered overflow/underflow flags. It sits in the datapath wherever a bounded event or position count is needed, for example sequencers, display scanning and timeout counters.

---
 rtl/ctr_pkg.sv | 22 ++
 rtl/ctr_next_val.sv | 57 +++++
 rtl/sync_updown_ctr_p.sv | 99 +++++++++
 tb/tb_sync_updown_ctr_p.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ctr_pkg.sv
// Shared definitions for the bounded up/down counter: direction/mode encodings
// and the load-value clamp helper.
package ctr_pkg;

    localparam logic CTR_MODE_WRAP = 1'b0;
    localparam logic CTR_MODE_SAT  = 1'b1;
    localparam logic CTR_DIR_UP    = 1'b0;
    localparam logic CTR_DIR_DN    = 1'b1;

    // Restrict v to the inclusive range [lo, hi].
    function automatic logic [31:0] ctr_clamp(input logic [31:0] v,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/ctr_next_val.sv
// Combinational next-count for one enabled step: wrap or saturate at the bounds,
// plus the overflow/underflow indication for that step.
module ctr_next_val
    import ctr_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 20,
    parameter int STEP_W  = 3
) (
    input  logic [WIDTH-1:0]  op,
    input  logic              ct,
    input  logic              mode,
    input  logic [STEP_W-1:0] s,
    output logic [WIDTH-1:0]  nxt,
    output logic              ovf_n,
    output logic              udf_n
);

    localparam int EW = WIDTH + 1;

    logic [EW-1:0]    op_e;
    logic [EW-1:0]    s_e;
    logic [WIDTH-1:0] s_w;
    logic [WIDTH-1:0] rng_w;

    // Bound checks use WIDTH+1 bits so carry/borrow survive; the resulting
    // value always lies in [MIN_VAL, MAX_VAL], so WIDTH-bit modular arithmetic
    // is exact for it.
    always_comb begin
        op_e  = {1'b0, op};
        s_e   = EW'(s);
        s_w   = WIDTH'(s);
        rng_w = WIDTH'(MAX_VAL - MIN_VAL + 1);
        nxt   = op;
        ovf_n = 1'b0;
        udf_n = 1'b0;
        if (ct == CTR_DIR_UP) begin
            ovf_n = (op_e + s_e) > EW'(MAX_VAL);
            if (!ovf_n)
                nxt = op + s_w;
            else if (mode == CTR_MODE_SAT)
                nxt = WIDTH'(MAX_VAL);
            else
                nxt = op + s_w - rng_w;
        end else begin
            udf_n = op_e < (EW'(MIN_VAL) + s_e);
            if (!udf_n)
                nxt = op - s_w;
            else if (mode == CTR_MODE_SAT)
                nxt = WIDTH'(MIN_VAL);
            else
                nxt = op + rng_w - s_w;
        end
    end

endmodule

// File: rtl/sync_updown_ctr_p.sv
// Bounded synchronous up/down counter with load, wrap/saturate and registered
// overflow/underflow flags. Define CTR_STEP_EN to add a variable step port.
module sync_updown_ctr_p
    import ctr_pkg::*;
#(
    parameter int WIDTH   = 5,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 20,
    parameter int RST_VAL = 0,
    parameter int STEP_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ct,
    input  logic              cn,
    input  logic              mode,
    input  logic              ld,
    input  logic [WIDTH-1:0]  ld_val,
`ifdef CTR_STEP_EN
    input  logic [STEP_W-1:0] step,
`endif
    output logic [WIDTH-1:0]  op,
    output logic              ovf,
    output logic              udf,
    output logic              at_max,
    output logic              at_min
);

    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL) begin : g_bad_bounds
        $error("sync_updown_ctr_p: need 0 <= MIN_VAL < MAX_VAL");
    end
    if (MAX_VAL >= (1 << WIDTH)) begin : g_bad_width
        $error("sync_updown_ctr_p: MAX_VAL does not fit in WIDTH");
    end
    if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_rst
        $error("sync_updown_ctr_p: RST_VAL outside [MIN_VAL, MAX_VAL]");
    end

    logic [WIDTH-1:0]  op_q, op_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [STEP_W-1:0] s;
    logic [WIDTH-1:0]  nxt;
    logic              ovf_n, udf_n;

`ifdef CTR_STEP_EN
    assign s = step;
`else
    assign s = STEP_W'(1);
`endif

    ctr_next_val #(
        .WIDTH  (WIDTH),
        .MIN_VAL(MIN_VAL),
        .MAX_VAL(MAX_VAL),
        .STEP_W (STEP_W)
    ) u_next (
        .op   (op_q),
        .ct   (ct),
        .mode (mode),
        .s    (s),
        .nxt  (nxt),
        .ovf_n(ovf_n),
        .udf_n(udf_n)
    );

    // Load beats count; flags are cleared on every cycle that does not count past a bound.
    always_comb begin
        op_d  = op_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (ld) begin
            op_d = WIDTH'(ctr_clamp(32'(ld_val), 32'(MIN_VAL), 32'(MAX_VAL)));
        end else if (cn) begin
            op_d  = nxt;
            ovf_d = ovf_n;
            udf_d = udf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= WIDTH'(RST_VAL);
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            op_q  <= op_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign op     = op_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;
    assign at_max = (op_q == WIDTH'(MAX_VAL));
    assign at_min = (op_q == WIDTH'(MIN_VAL));

endmodule

// File: tb/tb_sync_updown_ctr_p.sv
// Directed bench for sync_updown_ctr_p at default bounds (0..20, width 5).
module tb_sync_updown_ctr_p;

    logic       clk = 1'b0;
    logic       rst, ct, cn, mode, ld;
    logic [4:0] ld_val;
`ifdef CTR_STEP_EN
    logic [4:0] step;
`endif
    logic [4:0] op;
    logic       ovf, udf, at_max, at_min;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_updown_ctr_p #(
        .WIDTH  (5),
        .MIN_VAL(0),
        .MAX_VAL(20),
        .RST_VAL(0),
        .STEP_W (5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ct    (ct),
        .cn    (cn),
        .mode  (mode),
        .ld    (ld),
        .ld_val(ld_val),
`ifdef CTR_STEP_EN
        .step  (step),
`endif
        .op    (op),
        .ovf   (ovf),
        .udf   (udf),
        .at_max(at_max),
        .at_min(at_min)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_op, input bit e_ovf, input bit e_udf);
        chk({tag, ".op"},     32'(op),     32'(e_op));
        chk({tag, ".ovf"},    32'(ovf),    32'(e_ovf));
        chk({tag, ".udf"},    32'(udf),    32'(e_udf));
        chk({tag, ".at_max"}, 32'(at_max), 32'(e_op == 20));
        chk({tag, ".at_min"}, 32'(at_min), 32'(e_op == 0));
    endtask

    initial begin
        rst = 1'b1; ct = 1'b0; cn = 1'b0; mode = 1'b0; ld = 1'b0; ld_val = 5'd0;
`ifdef CTR_STEP_EN
        step = 5'd1;
`endif
        tick();
        chk_all("reset", 0, 1'b0, 1'b0);

        // Wrap up through the top bound.
        rst = 1'b0; cn = 1'b1; ct = 1'b0; mode = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            tick();
            chk_all($sformatf("wrap_up%0d", i), i % 21, i == 21, 1'b0);
        end

        // Wrap down through the bottom bound, then the flag drops.
        ct = 1'b1;
        tick();
        chk_all("wrap_dn", 20, 1'b0, 1'b1);
        cn = 1'b0;
        tick();
        chk_all("wrap_dn_hold", 20, 1'b0, 1'b0);

        // Saturate at the top.
        ld = 1'b1; ld_val = 5'd19;
        tick();
        chk_all("ld19", 19, 1'b0, 1'b0);
        ld = 1'b0; cn = 1'b1; ct = 1'b0; mode = 1'b1;
        tick();
        chk_all("sat_up1", 20, 1'b0, 1'b0);
        tick();
        chk_all("sat_up2", 20, 1'b1, 1'b0);
        tick();
        chk_all("sat_up3", 20, 1'b1, 1'b0);

        // Load clamp and load-over-count priority.
        cn = 1'b0; ld = 1'b1; ld_val = 5'd25;
        tick();
        chk_all("ld_clamp", 20, 1'b0, 1'b0);
        ld_val = 5'd7; cn = 1'b1; ct = 1'b0;
        tick();
        chk_all("ld_prio", 7, 1'b0, 1'b0);

        // Plain down count, then saturate at the bottom.
        ld = 1'b0; ct = 1'b1; mode = 1'b0;
        tick();
        chk_all("dn_plain", 6, 1'b0, 1'b0);
        ld = 1'b1; ld_val = 5'd0; cn = 1'b0;
        tick();
        ld = 1'b0; cn = 1'b1; ct = 1'b1; mode = 1'b1;
        tick();
        chk_all("sat_dn", 0, 1'b0, 1'b1);

        // Reset overrides load and count in the same cycle.
        cn = 1'b0; ld = 1'b1; ld_val = 5'd13;
        tick();
        chk_all("ld13", 13, 1'b0, 1'b0);
        rst = 1'b1; ld_val = 5'd9; cn = 1'b1; ct = 1'b0;
        tick();
        chk_all("rst_prio", 0, 1'b0, 1'b0);
        rst = 1'b0; ld = 1'b0; cn = 1'b0;

`ifdef CTR_STEP_EN
        ld = 1'b1; ld_val = 5'd18;
        tick();
        ld = 1'b0; cn = 1'b1; ct = 1'b0; mode = 1'b0; step = 5'd7;
        tick();
        chk_all("step7_wrap", 4, 1'b1, 1'b0);
        step = 5'd0;
        tick();
        chk_all("step0_hold", 4, 1'b0, 1'b0);
        cn = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
